// File: rtl/game_timer_pkg.sv
// +----------------------------------------------------------------------+
// | game_timer_pkg : shared constants, state encoding and BCD helper     |
// | Revision       : 1.0                                                 |
// +----------------------------------------------------------------------+
`default_nettype none

package game_timer_pkg;

  localparam int unsigned       BCD_W           = 4;
  localparam logic [BCD_W-1:0]  c_BCD_MAX_DIGIT = 4'd9;
  localparam logic [7:0]        c_DEFAULT_SECS  = 8'h60;
  localparam logic [7:0]        c_WARN_SECS     = 8'h10;

  localparam int unsigned       ST_W            = 2;
  localparam logic [ST_W-1:0]   c_ST_IDLE       = 2'd0;
  localparam logic [ST_W-1:0]   c_ST_RUNNING    = 2'd1;
  localparam logic [ST_W-1:0]   c_ST_PAUSED     = 2'd2;
  localparam logic [ST_W-1:0]   c_ST_EXPIRED    = 2'd3;

  // Saturate each nibble of a {tens, ones} value to a legal BCD digit.
  function automatic logic [7:0] bcd_clamp(input logic [7:0] i_v);
    logic [BCD_W-1:0] l_tens;
    logic [BCD_W-1:0] l_ones;
    l_tens = (i_v[7:4] > c_BCD_MAX_DIGIT) ? c_BCD_MAX_DIGIT : i_v[7:4];
    l_ones = (i_v[3:0] > c_BCD_MAX_DIGIT) ? c_BCD_MAX_DIGIT : i_v[3:0];
    return {l_tens, l_ones};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_dec2.sv
// +----------------------------------------------------------------------+
// | bcd_dec2 : two-digit BCD decrement (saturating at 00) with zero flag |
// | Revision : 1.0                                                       |
// +----------------------------------------------------------------------+
`default_nettype none

module bcd_dec2
  import game_timer_pkg::*;
(
  input  logic [7:0] i_bcd,
  output logic [7:0] o_bcd,
  output logic       o_zero
);

  always_comb begin
    o_bcd = i_bcd;
    if (i_bcd == 8'h00) begin
      o_bcd = 8'h00;
    end else if (i_bcd[3:0] == 4'd0) begin
      o_bcd = {i_bcd[7:4] - 4'd1, c_BCD_MAX_DIGIT};
    end else begin
      o_bcd = {i_bcd[7:4], i_bcd[3:0] - 4'd1};
    end
    o_zero = (o_bcd == 8'h00);
  end

endmodule

`default_nettype wire

// File: rtl/bcd_countdown_timer.sv
// +----------------------------------------------------------------------+
// | bcd_countdown_timer : ms-driven two-digit BCD round timer            |
// | Optional feature    : LOW_TIME_WARN_EN (registered low-time warning) |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
`default_nettype none

module bcd_countdown_timer
  import game_timer_pkg::*;
#(
  parameter int unsigned MS_PER_SEC   = 1000,
  parameter logic [7:0]  DEFAULT_SECS = c_DEFAULT_SECS
`ifdef LOW_TIME_WARN_EN
  ,
  parameter logic [7:0]  WARN_SECS    = c_WARN_SECS
`endif
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic       i_stop,
  input  logic       i_pause,
  input  logic [7:0] i_load_bcd,
  input  logic       i_ms_tick,
  output logic       o_tick_en,
  output logic [7:0] o_secs_bcd,
  output logic       o_running,
  output logic       o_time_up,
  output logic       o_warn
);

  localparam logic [9:0] c_MS_LAST = 10'(MS_PER_SEC - 1);

  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_state_nxt;
  logic [9:0]      r_ms_cnt;
  logic [9:0]      w_ms_nxt;
  logic [7:0]      r_secs;
  logic [7:0]      w_secs_nxt;
  logic            r_time_up;
  logic            w_time_up_nxt;

  logic [7:0]      w_load_clamped;
  logic [7:0]      w_load_val;
  logic [7:0]      w_dec_bcd;
  logic            w_dec_zero;
  logic            w_run_act;
  logic            w_start_ok;
  logic            w_sec_wrap;

  bcd_dec2 u_dec (
    .i_bcd  (r_secs),
    .o_bcd  (w_dec_bcd),
    .o_zero (w_dec_zero)
  );

  assign w_load_clamped = bcd_clamp(i_load_bcd);
  assign w_load_val     = (w_load_clamped == 8'h00) ? DEFAULT_SECS : w_load_clamped;
  assign w_run_act      = (r_state == c_ST_RUNNING) && !i_pause;
  assign w_start_ok     = i_start && ((r_state == c_ST_IDLE) || (r_state == c_ST_EXPIRED));
  assign w_sec_wrap     = w_run_act && i_ms_tick && (r_ms_cnt >= c_MS_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (i_stop) begin
      w_state_nxt = c_ST_IDLE;
    end else begin
      case (r_state)
        c_ST_IDLE, c_ST_EXPIRED: begin
          if (i_start) w_state_nxt = c_ST_RUNNING;
        end
        c_ST_RUNNING: begin
          if (i_pause)                       w_state_nxt = c_ST_PAUSED;
          else if (w_sec_wrap && w_dec_zero) w_state_nxt = c_ST_EXPIRED;
        end
        c_ST_PAUSED: begin
          if (!i_pause) w_state_nxt = c_ST_RUNNING;
        end
        default: w_state_nxt = c_ST_IDLE;
      endcase
    end
  end

  always_comb begin
    o_running = (r_state == c_ST_RUNNING) || (r_state == c_ST_PAUSED);
    o_tick_en = w_run_act;
  end

  // Datapath follows the same stop > start > pause > ms_tick priority as the FSM.
  always_comb begin
    w_ms_nxt      = r_ms_cnt;
    w_secs_nxt    = r_secs;
    w_time_up_nxt = 1'b0;
    if (i_stop) begin
      w_ms_nxt = 10'd0;
    end else if (w_start_ok) begin
      w_ms_nxt   = 10'd0;
      w_secs_nxt = w_load_val;
    end else if (w_run_act && i_ms_tick) begin
      if (w_sec_wrap) begin
        w_ms_nxt      = 10'd0;
        w_secs_nxt    = w_dec_bcd;
        w_time_up_nxt = w_dec_zero;
      end else begin
        w_ms_nxt = r_ms_cnt + 10'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ms_cnt  <= 10'd0;
      r_secs    <= 8'h00;
      r_time_up <= 1'b0;
    end else begin
      r_ms_cnt  <= w_ms_nxt;
      r_secs    <= w_secs_nxt;
      r_time_up <= w_time_up_nxt;
    end
  end

  assign o_secs_bcd = r_secs;
  assign o_time_up  = r_time_up;

`ifdef LOW_TIME_WARN_EN
  logic r_warn;
  logic w_running_nxt;

  // Computed from next-cycle values so warn lines up with secs_bcd.
  assign w_running_nxt = (w_state_nxt == c_ST_RUNNING) || (w_state_nxt == c_ST_PAUSED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_warn <= 1'b0;
    end else begin
      r_warn <= w_running_nxt && (w_secs_nxt <= WARN_SECS) && (w_secs_nxt != 8'h00);
    end
  end

  assign o_warn = r_warn;
`else
  assign o_warn = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bcd_countdown_timer.sv
// +----------------------------------------------------------------------+
// | tb_bcd_countdown_timer : directed + random bench with reference model|
// | Revision               : 1.0                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_bcd_countdown_timer;

  localparam int MS       = 4;
  localparam int DEF_SECS = 60;
  localparam int WARN_LVL = 3;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_EXP   = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_start, i_stop, i_pause, i_ms_tick;
  logic [7:0] i_load_bcd;
  logic       o_tick_en, o_running, o_time_up, o_warn;
  logic [7:0] o_secs_bcd;

  always #5 clk = ~clk;

  bcd_countdown_timer #(
    .MS_PER_SEC   (MS),
    .DEFAULT_SECS (8'h60)
`ifdef LOW_TIME_WARN_EN
    ,
    .WARN_SECS    (8'h03)
`endif
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_pause    (i_pause),
    .i_load_bcd (i_load_bcd),
    .i_ms_tick  (i_ms_tick),
    .o_tick_en  (o_tick_en),
    .o_secs_bcd (o_secs_bcd),
    .o_running  (o_running),
    .o_time_up  (o_time_up),
    .o_warn     (o_warn)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: plain decimal seconds and a millisecond count.
  int m_mode = M_IDLE;
  int m_secs = 0;
  int m_ms   = 0;
  bit m_tu   = 1'b0;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int s);
    return 8'(((s / 10) * 16) + (s % 10));
  endfunction

  function automatic int digit_clamp(input logic [3:0] d);
    return (d > 4'd9) ? 9 : int'(d);
  endfunction

  function automatic bit model_running();
    return (m_mode == M_RUN) || (m_mode == M_PAUSE);
  endfunction

  function automatic bit model_warn();
`ifdef LOW_TIME_WARN_EN
    return model_running() && (m_secs <= WARN_LVL) && (m_secs != 0);
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_edge(input bit st, input bit sp, input bit pa, input bit tk, input logic [7:0] ld);
    m_tu = 1'b0;
    if (sp) begin
      m_mode = M_IDLE;
      m_ms   = 0;
    end else if (st && (m_mode == M_IDLE || m_mode == M_EXP)) begin
      m_secs = digit_clamp(ld[7:4]) * 10 + digit_clamp(ld[3:0]);
      if (m_secs == 0) m_secs = DEF_SECS;
      m_ms   = 0;
      m_mode = M_RUN;
    end else if (m_mode == M_RUN && pa) begin
      m_mode = M_PAUSE;
    end else if (m_mode == M_PAUSE && !pa) begin
      m_mode = M_RUN;
    end else if (m_mode == M_RUN && tk) begin
      if (m_ms < MS - 1) begin
        m_ms++;
      end else begin
        m_ms = 0;
        if (m_secs > 0) m_secs--;
        if (m_secs == 0) begin
          m_mode = M_EXP;
          m_tu   = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc(input bit st, input bit sp, input bit pa, input bit tk, input logic [7:0] ld);
    i_start    = st;
    i_stop     = sp;
    i_pause    = pa;
    i_ms_tick  = tk;
    i_load_bcd = ld;
    #1;
    chk("tick_en", 8'(o_tick_en), 8'((m_mode == M_RUN) && !pa));
    @(posedge clk);
    model_edge(st, sp, pa, tk, ld);
    #1;
    chk("secs_bcd", o_secs_bcd, to_bcd(m_secs));
    chk("running", 8'(o_running), 8'(model_running()));
    chk("time_up", 8'(o_time_up), 8'(m_tu));
    chk("warn", 8'(o_warn), 8'(model_warn()));
  endtask

  task automatic idle_inputs();
    i_start = 1'b0; i_stop = 1'b0; i_pause = 1'b0; i_ms_tick = 1'b0; i_load_bcd = 8'h00;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_secs"},    o_secs_bcd,      8'h00);
    chk({tag, "_running"}, 8'(o_running),   8'h00);
    chk({tag, "_tick_en"}, 8'(o_tick_en),   8'h00);
    chk({tag, "_time_up"}, 8'(o_time_up),   8'h00);
    chk({tag, "_warn"},    8'(o_warn),      8'h00);
  endtask

  // Called just after a cyc(); drops reset between clock edges.
  task automatic async_reset();
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    m_mode = M_IDLE; m_secs = 0; m_ms = 0; m_tu = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    bit p_hold;
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    #3;
    rst_n = 1'b1;

    // 02 -> 01 on the 4th tick, 01 -> 00 on the 8th, one-cycle time_up.
    cyc(1, 0, 0, 0, 8'h02);
    for (int k = 1; k <= 8; k++) begin
      cyc(0, 0, 0, 1, 8'h00);
      if (k == 4) chk("dec_02_to_01", o_secs_bcd, 8'h01);
      if (k == 8) begin
        chk("expire_secs", o_secs_bcd, 8'h00);
        chk("expire_pulse", 8'(o_time_up), 8'h01);
      end
      cyc(0, 0, 0, 0, 8'h00);
      if (k == 8) chk("pulse_one_cycle", 8'(o_time_up), 8'h00);
      cyc(0, 0, 0, 0, 8'h00);
    end
    chk("expired_tick_en", 8'(o_tick_en), 8'h00);

    // Tens borrow, nibble clamp, zero load default.
    cyc(1, 0, 0, 0, 8'h10);
    repeat (4) cyc(0, 0, 0, 1, 8'h00);
    chk("borrow_10_to_09", o_secs_bcd, 8'h09);
    cyc(0, 1, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 8'h5F);
    chk("clamp_5F", o_secs_bcd, 8'h59);
    cyc(0, 1, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 8'h00);
    chk("default_load", o_secs_bcd, 8'h60);

    // Pause with ms_cnt=2 holds everything; two more ticks finish the second.
    repeat (2) cyc(0, 0, 0, 1, 8'h00);
    for (int i = 0; i < 20; i++) cyc(0, 0, 1, (i % 2) == 0, 8'h00);
    chk("pause_hold", o_secs_bcd, 8'h60);
    cyc(0, 0, 0, 0, 8'h00);
    repeat (2) cyc(0, 0, 0, 1, 8'h00);
    chk("pause_resume_dec", o_secs_bcd, 8'h59);

    // Stop coincident with the final wrap beats the expiry.
    cyc(0, 1, 0, 0, 8'h00);
    cyc(1, 0, 0, 0, 8'h01);
    repeat (3) cyc(0, 0, 0, 1, 8'h00);
    cyc(0, 1, 0, 1, 8'h00);
    chk("stop_wrap_secs", o_secs_bcd, 8'h01);
    chk("stop_wrap_tu", 8'(o_time_up), 8'h00);

    cyc(1, 1, 0, 0, 8'h22);
    chk("start_stop_idle", 8'(o_running), 8'h00);

    // Asynchronous reset mid-round, then ticks are ignored until start.
    cyc(1, 0, 0, 0, 8'h30);
    repeat (5) cyc(0, 0, 0, 1, 8'h00);
    async_reset();
    repeat (8) cyc(0, 0, 0, 1, 8'h00);
    chk("post_reset_idle", o_secs_bcd, 8'h00);

    // Random traffic against the model.
    p_hold = 1'b0;
    for (int n = 0; n < 4000; n++) begin
      logic [7:0] ld;
      bit st, sp, tk;
      case ($urandom_range(0, 5))
        0:       ld = 8'($urandom);
        1:       ld = 8'h00;
        2:       ld = 8'($urandom_range(1, 3));
        3:       ld = 8'h5F | 8'($urandom_range(0, 255) & 8'hA0);
        4:       ld = 8'h10;
        default: ld = 8'($urandom_range(4, 9));
      endcase
      if ($urandom_range(0, 99) < 3) p_hold = ~p_hold;
      st = ($urandom_range(0, 99) < 5);
      sp = ($urandom_range(0, 99) < 2);
      tk = ($urandom_range(0, 2) == 0);
      cyc(st, sp, p_hold, tk, ld);
      if ($urandom_range(0, 999) < 2) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bcd_countdown_timer.md
Name: bcd_countdown_timer

Overview:
Round timer for the BCD math game.
- Consumes the 1 ms timeout pulse from the LFSR millisecond stage.
- Drives that stage's enable input.
- Accumulates milliseconds into whole seconds and counts a two-digit BCD seconds value down to 00.
- Signals the game controller with a one-cycle time_up pulse when the round ends.

Parameters:
MS_PER_SEC, 1000, number of ms_tick pulses per second; legal range 2..1023; the ms counter is 10 bits wide.
DEFAULT_SECS, 8'h60, BCD value loaded when start sees an all-zero load value.
WARN_SECS, 8'h10, BCD threshold for the low-time warning. Used only when LOW_TIME_WARN_EN is defined.

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
start  input  1  one-cycle pulse; loads the count and begins a round
stop  input  1  one-cycle pulse; aborts the round and returns to IDLE
pause  input  1  level; while high in RUNNING or PAUSED, the timer holds
load_bcd  input  8  BCD seconds {tens, ones} sampled on start
ms_tick  input  1  1 ms pulse (the LFSR stage's timeout)
tick_en  output  1  enable to the LFSR stage
secs_bcd  output  8  remaining seconds, BCD {tens, ones}
running  output  1  high in RUNNING or PAUSED
time_up  output  1  one-cycle pulse at expiry
warn  output  1  low-time warning (tied 0 without the macro)

Behaviour:
- Reset (reset==0, asynchronous) forces:
  - state=IDLE, ms_cnt=0, secs_bcd=8'h00
  - tick_en=0, running=0, time_up=0, warn=0
- All other updates happen on posedge clk.
- States: IDLE, RUNNING, PAUSED, EXPIRED. Encoding lives in the package.
- Event priority per cycle: stop > start > pause > ms_tick.
- IDLE/EXPIRED + start:
  - Each load_bcd nibble >9 is clamped to 9.
  - If the clamped value is 00, DEFAULT_SECS is loaded instead.
  - ms_cnt=0; next state is RUNNING. No time_up pulse at start.
- start is ignored in RUNNING and PAUSED. A restart requires stop first.
- stop in any state: next state IDLE; secs_bcd is held, ms_cnt=0, no time_up.
- RUNNING + pause=1: next state PAUSED. PAUSED + pause=0: next state RUNNING. ms_cnt is preserved across the pause.
- RUNNING + ms_tick (pause=0):
  - If ms_cnt < MS_PER_SEC-1, ms_cnt increments.
  - Otherwise ms_cnt=0 and secs_bcd decrements in BCD. When ones==0, ones becomes 9 and tens decrements (e.g. 8'h40 -> 8'h39).
  - If the decrement produces 8'h00, the next state is EXPIRED and time_up=1 for exactly that one cycle.
- ms_tick outside RUNNING, or coincident with pause=1, is ignored.
- tick_en is combinational and equals (state==RUNNING && !pause). The LFSR stage therefore freezes its partial millisecond while paused.
- EXPIRED: secs_bcd holds 8'h00, running=0, tick_en=0, time_up=0 after the pulse cycle.
- secs_bcd never wraps below 00. No decrement occurs at 00.
- Latency: secs_bcd and time_up update on the clock edge that samples the qualifying ms_tick.

Optional Feature:
LOW_TIME_WARN_EN
- Defined: warn is registered and equals (running && secs_bcd <= WARN_SECS && secs_bcd != 00). The comparison is a BCD-valid numeric compare. warn clears on stop, on expiry, and on reset.
- Undefined: warn is tied to 0, and WARN_SECS is unused.

Decomposition:
- Shared package (game_timer_pkg):
  - state enum/localparams
  - BCD digit width (4)
  - DEFAULT_SECS and WARN_SECS defaults
  - BCD max digit constant (4'd9)
- Sub-module bcd_dec2: a two-digit BCD decrement with a zero flag, purely combinational and reusable by the score/answer logic.

Test Plan:
- MS_PER_SEC=4, load 8'h02, start, ms_tick every 3 cycles:
  - secs_bcd goes 02 -> 01 on the 4th tick and 01 -> 00 on the 8th tick.
  - time_up is high for exactly 1 cycle, then the state is EXPIRED with tick_en=0.
- Load 8'h10, run 4 ticks (MS_PER_SEC=4) -> secs_bcd=8'h09 (tens borrow). Load 8'h5F -> clamped to 8'h59. Load 8'h00 -> 8'h60.
- RUNNING with ms_cnt=2, pause=1 for 20 cycles with ms_tick pulses -> tick_en=0, secs and ms_cnt unchanged. Release pause, then 2 ticks -> one decrement.
- stop and ms_tick in the same cycle as the final-second wrap -> state IDLE, no time_up, secs_bcd unchanged. start and stop in the same cycle -> IDLE.
- Assert reset mid-round (asynchronous, between clock edges) -> all outputs zero immediately. After release, ms_tick pulses are ignored until start.
- LOW_TIME_WARN_EN, WARN_SECS=8'h03, load 8'h05 -> warn rises when secs_bcd becomes 03 and falls with time_up at 00.
